datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
Multi-cycle controller that sequences the instruction-ROM / register-file / ALU datapath. It owns the program counter and walks each instruction through FETCH, DECODE, EXECUTE and WRITEBACK. It supports two modes: single-step, driven by a debounced push-button, and free-run. It generates the ALU operation code, register write-enable and write-register select, so the top level no longer decodes opcodes combinationally.

Parameters:
PC_WIDTH, 3, width of program counter (program length 2**PC_WIDTH).
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to accept a button level change (min 2).
HALT_OPCODE, 6'b111111, opcode that stops execution.
WRAP_PC, 1, 1: PC wraps to 0 after last address; 0: sequencer enters HALT after executing last address.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
step_btn  in  1  raw asynchronous step button (active-high)
run_mode  in  1  1 = free-run, 0 = single-step; level, sampled in IDLE and at end of WRITEBACK
opcode  in  6  instruction[31:26] from the instruction ROM output
pc  out  PC_WIDTH  program counter to instruction ROM
ir_load  out  1  1-cycle pulse in FETCH: capture instruction register
alu_op  out  3  registered ALU operation code
reg_write  out  1  register-file write enable, 1-cycle pulse in WRITEBACK
write_sel_rd  out  1  1 = write rd, 0 = write rt
busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
halted  out  1  high in HALT
instr_count  out  8  retired-instruction counter, saturates at 255

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE; pc=0; alu_op=000; reg_write=0; ir_load=0; write_sel_rd=0; busy=0; halted=0; instr_count=0.
  - Debouncer stable level=0, its counter=0, synchronizer flops=0.
  - Reset wins over every other event, including mid-instruction; a pending reg_write is dropped.
- Debounce:
  - step_btn passes through a 2-flop synchronizer.
  - Counter increments each cycle the synced level differs from the stable level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable takes the synced level and the counter clears.
  - step_pulse is a 1-cycle pulse on the stable 0->1 transition. Latency from the first clk edge sampling step_btn=1 (held) to step_pulse high is DEBOUNCE_CYCLES+2 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse.
- State machine (one cycle per state, except IDLE and HALT):
  - IDLE: go to FETCH if run_mode=1 or step_pulse=1; otherwise stay.
  - FETCH: ir_load=1 this cycle; go to DECODE.
  - DECODE: latch alu_op and write_sel_rd from opcode. If opcode==HALT_OPCODE, go to HALT (no write, pc unchanged, instr_count unchanged). Otherwise go to EXECUTE.
  - EXECUTE: go to WRITEBACK; reg_write=0.
  - WRITEBACK:
    - reg_write=1 iff the decoded opcode is valid; instr_count += 1 (saturating).
    - pc: if pc==2**PC_WIDTH-1 and WRAP_PC==0, go to HALT with pc unchanged. Otherwise pc += 1 (mod 2**PC_WIDTH).
    - Next state is FETCH if run_mode=1, else IDLE.
  - HALT: halted=1; outputs frozen; only reset exits.
- Opcode decode, as {alu_op, write_sel_rd, valid}:
  - 010000 -> 010,1,1
  - 011000 -> 011,1,1
  - 100000 -> 100,1,1
  - 101000 -> 101,1,1
  - 110000 -> 110,0,1
  - 111000 -> 111,0,1
  - any other non-halt opcode -> 000,0,0: a NOP that still retires, increments pc and instr_count, and never asserts reg_write.
- alu_op and write_sel_rd hold their DECODE value through EXECUTE and WRITEBACK, and until the next DECODE.
- Throughput: 4 cycles per instruction in free-run. A single step takes 4 cycles from the IDLE exit back to IDLE.
- step_pulse arriving outside IDLE is discarded, not queued.
- run_mode falling during an instruction completes that instruction, then returns to IDLE.

Test Plan:
- Reset held low 3 cycles with run_mode=1 -> pc=0, state IDLE, all outputs 0. First cycle after reset=1: FETCH with ir_load=1.
- Single-step, DEBOUNCE_CYCLES=4, opcode=010000, step_btn held high 20 cycles -> exactly one instruction executes: reg_write pulse 1 cycle in WRITEBACK, alu_op=010, write_sel_rd=1, pc 0->1, instr_count=1, back to IDLE.
- Bounce on step_btn: 0/1 toggling every 2 cycles for 12 cycles, then 0 -> no step_pulse, pc stays 0.
- Free-run, WRAP_PC=1, opcodes cycling 110000 / 000001 -> reg_write every 8 cycles only for 110000, write_sel_rd=0, alu_op=110. pc wraps 7->0 after 32 cycles, instr_count=8.
- Free-run, opcode=111111 at pc=3 -> HALT entered from DECODE, halted=1, pc=3, instr_count=3, no further ir_load; a step press has no effect.
- reset=0 asserted during EXECUTE of a 100000 instruction -> no reg_write pulse, pc=0, instr_count=0 on the next cycle.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Multi-cycle sequencer for the instruction-ROM / register-file / ALU datapath.
// Owns the PC, walks FETCH/DECODE/EXECUTE/WRITEBACK, supports free-run and debounced single-step.
module datapath_sequencer #(
  parameter int         PC_WIDTH        = 3,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [5:0] HALT_OPCODE     = 6'b111111,
  parameter bit         WRAP_PC         = 1'b1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                step_btn_i,
  input  logic                run_mode_i,
  input  logic [5:0]          opcode_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                ir_load_o,
  output logic [2:0]          alu_op_o,
  output logic                reg_write_o,
  output logic                write_sel_rd_o,
  output logic                busy_o,
  output logic                halted_o,
  output logic [7:0]          instr_count_o
);

  localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] PC_LAST = {PC_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  // Returns {alu_op, write_sel_rd, valid}; unknown opcodes retire as NOPs.
  function automatic logic [4:0] decode_op(input logic [5:0] op);
    case (op)
      6'b010000: decode_op = 5'b010_1_1;
      6'b011000: decode_op = 5'b011_1_1;
      6'b100000: decode_op = 5'b100_1_1;
      6'b101000: decode_op = 5'b101_1_1;
      6'b110000: decode_op = 5'b110_0_1;
      6'b111000: decode_op = 5'b111_0_1;
      default:   decode_op = 5'b000_0_0;
    endcase
  endfunction

  logic [1:0]          sync_q;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                db_stable_q, db_stable_d;
  logic                db_prev_q;
  logic                step_pulse_q;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                ir_load_q;
  logic [2:0]          alu_op_q;
  logic                reg_write_q;
  logic                write_sel_rd_q;
  logic                valid_q;
  logic                busy_q;
  logic                halted_q;
  logic [7:0]          instr_count_q;
  logic [4:0]          dec_s;

  assign dec_s = decode_op(opcode_i);

  // Debounce next-state: a level change is accepted after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    db_cnt_d    = db_cnt_q;
    db_stable_d = db_stable_q;
    if (sync_q[1] != db_stable_q) begin
      if (db_cnt_q == DB_MAX) begin
        db_stable_d = sync_q[1];
        db_cnt_d    = {DB_W{1'b0}};
      end else begin
        db_cnt_d    = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = {DB_W{1'b0}};
    end
  end

  // Synchronizer, debounce state and rising-edge step pulse.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sync_q       <= 2'b00;
      db_cnt_q     <= {DB_W{1'b0}};
      db_stable_q  <= 1'b0;
      db_prev_q    <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], step_btn_i};
      db_cnt_q     <= db_cnt_d;
      db_stable_q  <= db_stable_d;
      db_prev_q    <= db_stable_q;
      step_pulse_q <= db_stable_q & ~db_prev_q;
    end
  end

  // Instruction sequencer with registered control outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q        <= S_IDLE;
      pc_q           <= {PC_WIDTH{1'b0}};
      ir_load_q      <= 1'b0;
      alu_op_q       <= 3'b000;
      reg_write_q    <= 1'b0;
      write_sel_rd_q <= 1'b0;
      valid_q        <= 1'b0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
      instr_count_q  <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_mode_i || step_pulse_q) begin
            state_q   <= S_FETCH;
            ir_load_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q   <= S_DECODE;
          ir_load_q <= 1'b0;
        end
        S_DECODE: begin
          {alu_op_q, write_sel_rd_q, valid_q} <= dec_s;
          if (opcode_i == HALT_OPCODE) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q  <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          state_q     <= S_WRITEBACK;
          reg_write_q <= valid_q;
        end
        S_WRITEBACK: begin
          reg_write_q <= 1'b0;
          if (instr_count_q != 8'd255) begin
            instr_count_q <= instr_count_q + 8'd1;
          end
          // Without wrapping, the last address retires and then parks the sequencer.
          if (pc_q == PC_LAST && !WRAP_PC) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            pc_q <= pc_q + PC_WIDTH'(1);
            if (run_mode_i) begin
              state_q   <= S_FETCH;
              ir_load_q <= 1'b1;
            end else begin
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
            end
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q     <= S_IDLE;
          ir_load_q   <= 1'b0;
          reg_write_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o           = pc_q;
  assign ir_load_o      = ir_load_q;
  assign alu_op_o       = alu_op_q;
  assign reg_write_o    = reg_write_q;
  assign write_sel_rd_o = write_sel_rd_q;
  assign busy_o         = busy_q;
  assign halted_o       = halted_q;
  assign instr_count_o  = instr_count_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed phases with randomized opcodes
// and button glitches, checked against an instruction-level reference model.
module tb_datapath_sequencer;
  localparam int PCW = 3;
  localparam int DEB = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           step_btn;
  logic           run_mode;
  logic [5:0]     opcode;
  logic [PCW-1:0] pc;
  logic           ir_load;
  logic [2:0]     alu_op;
  logic           reg_write;
  logic           write_sel_rd;
  logic           busy;
  logic           halted;
  logic [7:0]     instr_count;

  logic [5:0]     rom [0:7];
  int             checks = 0;
  int             failures = 0;
  int             model_pc;
  int             model_count;
  int             ir_seen;
  int             cyc = 0;
  int             waited;
  int             t_start;
  bit             hit;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign opcode = rom[pc];

  datapath_sequencer #(
    .PC_WIDTH(PCW), .DEBOUNCE_CYCLES(DEB), .HALT_OPCODE(6'b111111), .WRAP_PC(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .step_btn_i(step_btn), .run_mode_i(run_mode),
    .opcode_i(opcode), .pc_o(pc), .ir_load_o(ir_load), .alu_op_o(alu_op),
    .reg_write_o(reg_write), .write_sel_rd_o(write_sel_rd), .busy_o(busy),
    .halted_o(halted), .instr_count_o(instr_count)
  );

  // Reference decode table: {alu_op, write_sel_rd, valid}
  function automatic logic [4:0] ref_decode(input logic [5:0] op);
    case (op)
      6'b010000: return 5'b01011;
      6'b011000: return 5'b01111;
      6'b100000: return 5'b10011;
      6'b101000: return 5'b10111;
      6'b110000: return 5'b11001;
      6'b111000: return 5'b11101;
      default:   return 5'b00000;
    endcase
  endfunction

  function automatic logic [5:0] rand_op();
    logic [5:0] v;
    if ($urandom_range(0, 1) == 0) v = {3'($urandom_range(2, 7)), 3'b000};
    else                           v = 6'($urandom_range(0, 62));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (ir_load === 1'b1) ir_seen++;
    end
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    model_pc = 0;
    model_count = 0;
  endtask

  // Follow one instruction from its FETCH cycle to WRITEBACK (or HALT) and update the model.
  task automatic run_instr(input int max_wait, output int w, output bit hit_halt);
    logic [4:0] exp;
    w = 0;
    hit_halt = 1'b0;
    while (ir_load !== 1'b1 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    chk("fetch_ir_load", ir_load, 1);
    chk("fetch_pc", pc, model_pc);
    chk("fetch_count", instr_count, model_count);
    chk("fetch_busy", busy, 1);
    exp = ref_decode(rom[model_pc]);
    @(negedge clk);
    chk("decode_ir_load", ir_load, 0);
    @(negedge clk);
    if (rom[model_pc] == 6'b111111) begin
      hit_halt = 1'b1;
      chk("halt_flag", halted, 1);
      chk("halt_busy", busy, 0);
      chk("halt_pc", pc, model_pc);
    end else begin
      chk("exec_alu", alu_op, exp[4:2]);
      chk("exec_sel", write_sel_rd, exp[1]);
      chk("exec_rw", reg_write, 0);
      @(negedge clk);
      chk("wb_rw", reg_write, exp[0]);
      chk("wb_alu", alu_op, exp[4:2]);
      chk("wb_sel", write_sel_rd, exp[1]);
      model_pc = (model_pc + 1) % 8;
      if (model_count < 255) model_count++;
    end
  endtask

  initial begin
    step_btn = 1'b0;
    run_mode = 1'b1;
    for (int i = 0; i < 8; i++) rom[i] = 6'b010000;
    hold_reset();
    chk("rst_pc", pc, 0);
    chk("rst_ir_load", ir_load, 0);
    chk("rst_alu", alu_op, 0);
    chk("rst_rw", reg_write, 0);
    chk("rst_sel", write_sel_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_count", instr_count, 0);

    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_ir_load", ir_load, 1);
    chk("rel_busy", busy, 1);
    chk("rel_pc", pc, 0);
    reset_n = 1'b0;
    run_mode = 1'b0;
    @(negedge clk);
    chk("rst_fetch_ir_load", ir_load, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Single step with the button held
    step_btn = 1'b1;
    run_instr(40, waited, hit);
    chk("step_latency", waited, DEB + 4);
    @(negedge clk);
    chk("step_back_idle", busy, 0);
    ir_seen = 0;
    idle_cycles(12);
    step_btn = 1'b0;
    idle_cycles(DEB + 4);
    chk("held_no_repeat", ir_seen, 0);
    chk("step_pc", pc, 1);
    chk("step_count", instr_count, 1);

    // Bouncing button: regular toggling, then random short glitches
    ir_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step_btn = 1'b1; idle_cycles(2);
      step_btn = 1'b0; idle_cycles(2);
    end
    idle_cycles(8);
    for (int g = 0; g < 6; g++) begin
      step_btn = 1'b1; idle_cycles($urandom_range(1, DEB - 1));
      step_btn = 1'b0; idle_cycles($urandom_range(1, 5));
    end
    idle_cycles(DEB + 4);
    chk("bounce_no_step", ir_seen, 0);
    chk("bounce_pc", pc, model_pc);

    // Random single-step presses with random opcodes
    for (int k = 0; k < 5; k++) begin
      rom[model_pc] = rand_op();
      step_btn = 1'b1;
      run_instr(40, waited, hit);
      chk("rstep_latency", waited, DEB + 4);
      ir_seen = 0;
      idle_cycles($urandom_range(1, 6));
      step_btn = 1'b0;
      idle_cycles(DEB + 4);
      chk("rstep_one_only", ir_seen, 0);
      chk("rstep_busy", busy, 0);
    end
    chk("rstep_pc", pc, model_pc);
    chk("rstep_count", instr_count, model_count);

    // Free-run alternating 110000 / 000001 with PC wrap
    hold_reset();
    for (int i = 0; i < 8; i++) rom[i] = (i % 2 == 1) ? 6'b000001 : 6'b110000;
    run_mode = 1'b1;
    reset_n = 1'b1;
    t_start = cyc;
    for (int i = 0; i < 8; i++) begin
      run_instr(8, waited, hit);
      chk("fr_throughput", waited, 1);
    end
    @(negedge clk);
    chk("wrap_pc", pc, 0);
    chk("wrap_count", instr_count, 8);
    chk("wrap_cycles", cyc - t_start, 33);

    // Long random free-run: counter saturates at 255
    for (int i = 0; i < 250; i++) begin
      rom[model_pc] = rand_op();
      run_instr(8, waited, hit);
      chk("rfr_throughput", waited, (i == 0) ? 0 : 1);
    end
    run_mode = 1'b0;
    ir_seen = 0;
    idle_cycles(3);
    chk("stop_no_fetch", ir_seen, 0);
    chk("stop_busy", busy, 0);
    chk("sat_count", instr_count, 255);
    chk("stop_pc", pc, model_pc);

    // HALT opcode at pc 3
    hold_reset();
    for (int i = 0; i < 3; i++) rom[i] = rand_op();
    rom[3] = 6'b111111;
    run_mode = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) run_instr(8, waited, hit);
    chk("halt_hit", hit, 1);
    ir_seen = 0;
    idle_cycles(5);
    step_btn = 1'b1;
    idle_cycles(DEB + 6);
    step_btn = 1'b0;
    idle_cycles(DEB + 4);
    chk("halt_no_fetch", ir_seen, 0);
    chk("halt_stays", halted, 1);
    chk("halt_pc_final", pc, 3);
    chk("halt_count", instr_count, 3);
    chk("halt_rw", reg_write, 0);

    // Reset during EXECUTE drops the pending write
    hold_reset();
    rom[0] = 6'b100000;
    run_mode = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_fetch", ir_load, 1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_exec_alu", alu_op, 3'b100);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rw", reg_write, 0);
    chk("mid_pc", pc, 0);
    chk("mid_count", instr_count, 0);
    chk("mid_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
